// File: rtl/decoder_n_seq.sv
// rtl/decoder_n_seq.sv - registered N-to-2^N decoder with one-hot, thermometer and self-timed scan modes
module decoder_n_seq #(
    parameter int N    = 2,
    parameter int HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    sel,
    input  logic            load,
    output logic [2**N-1:0] y,
    output logic            valid,
    output logic [N-1:0]    idx,
    output logic            wrap
);
    localparam int L  = 2**N;
    localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD - 1);
    localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    mode_e mode_w;
    assign mode_w = mode_e'(mode);

    logic [L-1:0]  y_q, y_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          wrap_q, wrap_d;
    // Set once an enabled scan edge has shown an index; cleared by any
    // other enabled mode so the next scan entry restarts at index 0.
    logic          active_q, active_d;

    function automatic logic [L-1:0] onehot(input logic [N-1:0] v);
        logic [L-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

    function automatic logic [L-1:0] therm(input logic [N-1:0] v);
        logic [L-1:0] r;
        for (int i = 0; i < L; i++) begin
            r[i] = (i <= int'(v));
        end
        return r;
    endfunction

    // Next-state decode for all modes; en low freezes scan state and blanks the output.
    always_comb begin
        y_d      = '0;
        valid_d  = 1'b0;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        wrap_d   = 1'b0;
        active_d = active_q;
        if (en) begin
            case (mode_w)
                MODE_ONEHOT: begin
                    y_d      = onehot(sel);
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    dwell_d  = '0;
                    active_d = 1'b0;
                end
                MODE_THERM: begin
                    y_d      = therm(sel);
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    dwell_d  = '0;
                    active_d = 1'b0;
                end
                MODE_SCAN: begin
                    valid_d  = 1'b1;
                    active_d = 1'b1;
                    if (load) begin
                        // load wins over dwell expiry and never reports a wrap
                        idx_d   = sel;
                        dwell_d = '0;
                    end else if (!active_q) begin
                        // entry edge: index 0 starts its first dwell cycle
                        idx_d   = '0;
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        idx_d   = idx_q + N'(1);
                        dwell_d = '0;
                        wrap_d  = (idx_q == IDX_LAST);
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                    y_d = onehot(idx_d);
                end
                default: begin
                    idx_d    = '0;
                    dwell_d  = '0;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    // Output and scan-state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q      <= '0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            dwell_q  <= '0;
            wrap_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            wrap_q   <= wrap_d;
            active_q <= active_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
    assign idx   = idx_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_n_seq.sv
// tb/tb_decoder_n_seq.sv - scoreboard bench for decoder_n_seq across three parameter sets
module tb_decoder_n_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // A: N=2 HOLD=3, B: N=3 HOLD=1, C: N=2 HOLD=2
    logic       en_a = 0, load_a = 0, valid_a, wrap_a;
    logic [1:0] mode_a = 0, sel_a = 0, idx_a;
    logic [3:0] y_a;
    logic       en_b = 0, load_b = 0, valid_b, wrap_b;
    logic [1:0] mode_b = 0;
    logic [2:0] sel_b = 0, idx_b;
    logic [7:0] y_b;
    logic       en_c = 0, load_c = 0, valid_c, wrap_c;
    logic [1:0] mode_c = 0, sel_c = 0, idx_c;
    logic [3:0] y_c;

    decoder_n_seq #(.N(2), .HOLD(3)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .sel(sel_a), .load(load_a),
        .y(y_a), .valid(valid_a), .idx(idx_a), .wrap(wrap_a));
    decoder_n_seq #(.N(3), .HOLD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .mode(mode_b), .sel(sel_b), .load(load_b),
        .y(y_b), .valid(valid_b), .idx(idx_b), .wrap(wrap_b));
    decoder_n_seq #(.N(2), .HOLD(2)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .mode(mode_c), .sel(sel_c), .load(load_c),
        .y(y_c), .valid(valid_c), .idx(idx_c), .wrap(wrap_c));

    typedef struct {
        int         inst;
        int         tag;
        logic [7:0] y;
        logic       v;
        logic [2:0] idx;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int tag_n = 0;

    task automatic check(input string name, input int tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, tag, got, exp);
        end
    endtask

    task automatic drive(input int inst, input logic e, input logic [1:0] m, input logic [2:0] s,
                         input logic ld, input logic [7:0] ey, input logic ev,
                         input logic [2:0] ei, input logic ew);
        exp_t x;
        @(negedge clk);
        case (inst)
            0: begin en_a = e; mode_a = m; sel_a = s[1:0]; load_a = ld; end
            1: begin en_b = e; mode_b = m; sel_b = s;      load_b = ld; end
            default: begin en_c = e; mode_c = m; sel_c = s[1:0]; load_c = ld; end
        endcase
        x.inst = inst; x.tag = tag_n; x.y = ey; x.v = ev; x.idx = ei; x.w = ew;
        tag_n++;
        sb.push_back(x);
    endtask

    // Monitor: compares the response to each issued vector one edge later.
    always @(posedge clk) begin
        exp_t e;
        logic [7:0] gy;
        logic       gv, gw;
        logic [2:0] gi;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin gy = {4'b0, y_a}; gv = valid_a; gi = {1'b0, idx_a}; gw = wrap_a; end
                1: begin gy = y_b;         gv = valid_b; gi = idx_b;         gw = wrap_b; end
                default: begin gy = {4'b0, y_c}; gv = valid_c; gi = {1'b0, idx_c}; gw = wrap_c; end
            endcase
            check("y",     e.tag, gy,         e.y);
            check("valid", e.tag, {7'b0, gv}, {7'b0, e.v});
            check("idx",   e.tag, {5'b0, gi}, {5'b0, e.idx});
            check("wrap",  e.tag, {7'b0, gw}, {7'b0, e.w});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog step=%0d got=timeout want=finish", tag_n);
        $fatal(1, "watchdog");
    end

    int a_seq[22] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0,0,1,1,1,2,2,2,3};
    int k_i;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_y_a",     -1, {4'b0, y_a},       8'h00);
        check("rst_valid_a", -1, {7'b0, valid_a},   8'h00);
        check("rst_idx_a",   -1, {6'b0, idx_a},     8'h00);
        check("rst_wrap_a",  -1, {7'b0, wrap_a},    8'h00);
        check("rst_y_b",     -1, y_b,               8'h00);
        check("rst_y_c",     -1, {4'b0, y_c},       8'h00);
        rst_n = 1'b1;

        // one-hot sweep, N=2
        drive(0, 1, 2'b00, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(0, 1, 2'b00, 3'd1, 0, 8'h02, 1, 0, 0);
        drive(0, 1, 2'b00, 3'd2, 0, 8'h04, 1, 0, 0);
        drive(0, 1, 2'b00, 3'd3, 0, 8'h08, 1, 0, 0);
        drive(0, 1, 2'b00, 3'd2, 1, 8'h04, 1, 0, 0);

        // thermometer and disable, N=3
        drive(1, 1, 2'b01, 3'd4, 0, 8'h1F, 1, 0, 0);
        drive(1, 1, 2'b01, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(1, 1, 2'b01, 3'd7, 0, 8'hFF, 1, 0, 0);
        drive(1, 1, 2'b00, 3'd5, 0, 8'h20, 1, 0, 0);
        drive(1, 0, 2'b01, 3'd4, 0, 8'h00, 0, 0, 0);

        // load priority on dwell expiry and freeze, HOLD=2
        drive(2, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(2, 1, 2'b10, 3'd2, 1, 8'h04, 1, 2, 0);
        drive(2, 0, 2'b10, 3'd0, 0, 8'h00, 0, 2, 0);
        drive(2, 0, 2'b10, 3'd1, 1, 8'h00, 0, 2, 0);
        drive(2, 0, 2'b10, 3'd0, 0, 8'h00, 0, 2, 0);
        drive(2, 0, 2'b10, 3'd0, 0, 8'h00, 0, 2, 0);
        drive(2, 0, 2'b10, 3'd0, 0, 8'h00, 0, 2, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h04, 1, 2, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h08, 1, 3, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h08, 1, 3, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 1);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h02, 1, 1, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h02, 1, 1, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h04, 1, 2, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h04, 1, 2, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h08, 1, 3, 0);
        drive(2, 1, 2'b10, 3'd0, 0, 8'h08, 1, 3, 0);
        drive(2, 1, 2'b10, 3'd0, 1, 8'h01, 1, 0, 0);

        // HOLD=1, N=3: index every cycle, wrap every 8
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 2'b10, 3'd0, 0, 8'(1 << (k % 8)), 1, 3'(k % 8), (k == 8) || (k == 16));
        end

        // scan dwell and wrap, HOLD=3, continuing on to idx=3
        for (int k = 0; k < 22; k++) begin
            k_i = a_seq[k];
            drive(0, 1, 2'b10, 3'd0, 0, 8'(1 << k_i), 1, 3'(k_i), k == 12);
        end
        // mode exit, reserved mode, re-entry
        drive(0, 1, 2'b00, 3'd1, 0, 8'h02, 1, 0, 0);
        drive(0, 1, 2'b11, 3'd2, 0, 8'h00, 0, 0, 0);
        drive(0, 1, 2'b10, 3'd3, 0, 8'h01, 1, 0, 0);
        drive(0, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);

        // asynchronous reset between edges
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("amid_y_a",     -2, {4'b0, y_a},     8'h00);
        check("amid_valid_a", -2, {7'b0, valid_a}, 8'h00);
        check("amid_idx_a",   -2, {6'b0, idx_a},   8'h00);
        check("amid_wrap_a",  -2, {7'b0, wrap_a},  8'h00);
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(0, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(0, 1, 2'b10, 3'd0, 0, 8'h01, 1, 0, 0);
        drive(0, 1, 2'b10, 3'd0, 0, 8'h02, 1, 1, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", -3, 8'(sb.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
